// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if -- decode/pipeline control bundle between the ID stage and ctrl_pipe.
//   master : drives the ID-stage request (ctrl_in, id_valid, id_rs, id_rt) and the
//            EX-stage ALU zero flag; observes the staged controls and status.
//   slave  : ctrl_pipe itself; consumes the request and produces the EX/MEM/WB
//            controls, stall_id, pc_redirect and retire_cnt.
interface ctrl_pipe_if;
  logic [9:0]  ctrl_in;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_zero;

  logic        ex_RegDst;
  logic [1:0]  ex_ALUop;
  logic        ex_ALUSrc;
  logic        mem_jump;
  logic        mem_Branch;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic        wb_RegWrite;
  logic        wb_MemtoReg;
  logic        stall_id;
  logic        pc_redirect;
  logic [15:0] retire_cnt;

  modport master (
    output ctrl_in, id_valid, id_rs, id_rt, ex_zero,
    input  ex_RegDst, ex_ALUop, ex_ALUSrc,
    input  mem_jump, mem_Branch, mem_MemRead, mem_MemWrite,
    input  wb_RegWrite, wb_MemtoReg,
    input  stall_id, pc_redirect, retire_cnt
  );

  modport slave (
    input  ctrl_in, id_valid, id_rs, id_rt, ex_zero,
    output ex_RegDst, ex_ALUop, ex_ALUSrc,
    output mem_jump, mem_Branch, mem_MemRead, mem_MemWrite,
    output wb_RegWrite, wb_MemtoReg,
    output stall_id, pc_redirect, retire_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- control-path pipeline for a classic 5-stage core.
// Carries decoded control bits from ID through EX, MEM and WB, detects the
// load-use hazard (stall_id), resolves jumps/taken branches in MEM
// (pc_redirect, squashing the two younger instructions) and counts retirements.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, clears every register
//   bus  : ctrl_pipe_if.slave
//          in : ctrl_in[9:0] {RegDst,ALUop[1:0],ALUSrc,jump,Branch,MemRead,
//               MemWrite,RegWrite,MemtoReg}, id_valid, id_rs, id_rt, ex_zero
//          out: ex_RegDst, ex_ALUop, ex_ALUSrc, mem_jump, mem_Branch,
//               mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg,
//               stall_id, pc_redirect, retire_cnt[15:0]
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  // ID/EX: full control bundle, rt for hazard compare, valid
  logic [9:0]  ctrl_p0;
  logic [4:0]  rt_p0;
  logic        vld_p0;
  // EX/MEM: MEM+WB control bits, latched zero flag, valid
  logic [5:0]  ctrl_p1;
  logic        zero_p1;
  logic        vld_p1;
  // MEM/WB: WB control bits, valid
  logic [1:0]  ctrl_p2;
  logic        vld_p2;

  logic [15:0] retire_cnt;
  logic        hazard;
  logic        redirect;
  logic        stall;
  logic        id_take;

  // Load in EX whose destination is a source of the ID instruction.
  // r0 is never a real dependency.
  always_comb begin
    hazard = vld_p0 & ctrl_p0[3] & (rt_p0 != 5'd0) & bus.id_valid &
             ((rt_p0 == bus.id_rs) | (rt_p0 == bus.id_rt));
  end

  // Jump, or branch whose EX-time zero flag was set, now sitting in MEM.
  always_comb begin
    redirect = vld_p1 & (ctrl_p1[5] | (ctrl_p1[4] & zero_p1));
  end

  // A redirect flushes the ID instruction anyway, so it overrides the stall.
  always_comb begin
    stall   = hazard & ~redirect;
    id_take = bus.id_valid & ~stall & ~redirect;
  end

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p0 <= 10'd0;
      rt_p0   <= 5'd0;
      vld_p0  <= 1'b0;
    end else if (id_take) begin
      ctrl_p0 <= bus.ctrl_in;
      rt_p0   <= bus.id_rt;
      vld_p0  <= 1'b1;
    end else begin
      ctrl_p0 <= 10'd0;
      rt_p0   <= 5'd0;
      vld_p0  <= 1'b0;
    end
  end

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p1 <= 6'd0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (!redirect) begin
      ctrl_p1 <= ctrl_p0[5:0];
      zero_p1 <= bus.ex_zero;
      vld_p1  <= vld_p0;
    end else begin
      ctrl_p1 <= 6'd0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end
  end

  // ---- MEM -> WB boundary ----
  // Never squashed: the redirecting instruction itself still retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p2 <= 2'd0;
      vld_p2  <= 1'b0;
    end else begin
      ctrl_p2 <= ctrl_p1[1:0];
      vld_p2  <= vld_p1;
    end
  end

  // ---- WB -> retire ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= 16'd0;
    end else if (vld_p2) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

  assign bus.ex_RegDst    = ctrl_p0[9];
  assign bus.ex_ALUop     = ctrl_p0[8:7];
  assign bus.ex_ALUSrc    = ctrl_p0[6];
  assign bus.mem_jump     = ctrl_p1[5];
  assign bus.mem_Branch   = ctrl_p1[4];
  assign bus.mem_MemRead  = ctrl_p1[3];
  assign bus.mem_MemWrite = ctrl_p1[2];
  assign bus.wb_RegWrite  = ctrl_p2[1];
  assign bus.wb_MemtoReg  = ctrl_p2[0];
  assign bus.stall_id     = stall;
  assign bus.pc_redirect  = redirect;
  assign bus.retire_cnt   = retire_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- self-checking bench for ctrl_pipe.
// Reference model tracks instructions (history queues indexed by instruction
// id) occupying the EX, MEM and WB slots; outputs are that instruction's
// control bits, or 0 for an empty slot.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if bus ();

  ctrl_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [9:0] RTYPE = 10'b1100000010;
  localparam logic [9:0] LW    = 10'b0001001011;
  localparam logic [9:0] BEQ   = 10'b0010010000;
  localparam logic [9:0] JMP   = 10'b0110100000;

  int errors = 0;
  int checks = 0;

  // instruction history and slot occupancy (-1 = empty slot)
  logic [9:0]  h_ctrl[$];
  logic [4:0]  h_rt[$];
  logic        h_zero[$];
  int          ex_i, mem_i, wb_i;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h_ctrl.delete();
    h_rt.delete();
    h_zero.delete();
    ex_i  = -1;
    mem_i = -1;
    wb_i  = -1;
    m_cnt = 16'd0;
  endtask

  function automatic logic m_hazard();
    logic [9:0] c;
    logic [4:0] r;
    if (ex_i < 0) return 1'b0;
    c = h_ctrl[ex_i];
    r = h_rt[ex_i];
    return c[3] && (r != 5'd0) && bus.id_valid &&
           ((r == bus.id_rs) || (r == bus.id_rt));
  endfunction

  function automatic logic m_redirect();
    logic [9:0] c;
    if (mem_i < 0) return 1'b0;
    c = h_ctrl[mem_i];
    return c[5] || (c[4] && h_zero[mem_i]);
  endfunction

  task automatic model_step();
    logic red, st;
    red = m_redirect();
    st  = m_hazard() && !red;
    if (wb_i >= 0) m_cnt = m_cnt + 16'd1;
    wb_i = mem_i;
    if (red) begin
      mem_i = -1;
    end else begin
      if (ex_i >= 0) h_zero[ex_i] = bus.ex_zero;
      mem_i = ex_i;
    end
    if (bus.id_valid && !st && !red) begin
      h_ctrl.push_back(bus.ctrl_in);
      h_rt.push_back(bus.id_rt);
      h_zero.push_back(1'b0);
      ex_i = h_ctrl.size() - 1;
    end else begin
      ex_i = -1;
    end
  endtask

  task automatic check_all();
    logic [9:0] ce, cm, cw;
    logic red;
    ce  = (ex_i  >= 0) ? h_ctrl[ex_i]  : 10'd0;
    cm  = (mem_i >= 0) ? h_ctrl[mem_i] : 10'd0;
    cw  = (wb_i  >= 0) ? h_ctrl[wb_i]  : 10'd0;
    red = m_redirect();
    chk("ex_RegDst",    16'(bus.ex_RegDst),    16'(ce[9]));
    chk("ex_ALUop",     16'(bus.ex_ALUop),     16'(ce[8:7]));
    chk("ex_ALUSrc",    16'(bus.ex_ALUSrc),    16'(ce[6]));
    chk("mem_jump",     16'(bus.mem_jump),     16'(cm[5]));
    chk("mem_Branch",   16'(bus.mem_Branch),   16'(cm[4]));
    chk("mem_MemRead",  16'(bus.mem_MemRead),  16'(cm[3]));
    chk("mem_MemWrite", 16'(bus.mem_MemWrite), 16'(cm[2]));
    chk("wb_RegWrite",  16'(bus.wb_RegWrite),  16'(cw[1]));
    chk("wb_MemtoReg",  16'(bus.wb_MemtoReg),  16'(cw[0]));
    chk("stall_id",     16'(bus.stall_id),     16'(m_hazard() && !red));
    chk("pc_redirect",  16'(bus.pc_redirect),  16'(red));
    chk("retire_cnt",   bus.retire_cnt,        m_cnt);
  endtask

  // drive ID inputs after a falling edge, then check combinational outputs
  task automatic set_in(input logic [9:0] c, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic z);
    @(negedge clk);
    bus.ctrl_in  = c;
    bus.id_valid = v;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.ex_zero  = z;
    #1;
    check_all();
  endtask

  task automatic edge_chk();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic tick(input logic [9:0] c, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic z);
    set_in(c, v, rs, rt, z);
    edge_chk();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(10'd0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.ctrl_in  = 10'd0;
    bus.id_valid = 1'b0;
    bus.id_rs    = 5'd0;
    bus.id_rt    = 5'd0;
    bus.ex_zero  = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] c;
    logic       v, held;
    logic [4:0] rs, rt;

    rst          = 1'b1;
    bus.ctrl_in  = 10'd0;
    bus.id_valid = 1'b0;
    bus.id_rs    = 5'd0;
    bus.id_rt    = 5'd0;
    bus.ex_zero  = 1'b0;
    model_reset();
    #1;
    chk("rst_retire_cnt", bus.retire_cnt, 16'd0);
    chk("rst_ex_RegDst",  16'(bus.ex_RegDst), 16'd0);
    chk("rst_wb_RegWrite", 16'(bus.wb_RegWrite), 16'd0);
    chk("rst_stall_id",   16'(bus.stall_id), 16'd0);
    chk("rst_pc_redirect", 16'(bus.pc_redirect), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type through all stages
    tick(RTYPE, 1'b1, 5'd1, 5'd2, 1'b0);
    chk("rtype_ex_RegDst", 16'(bus.ex_RegDst), 16'd1);
    chk("rtype_ex_ALUop",  16'(bus.ex_ALUop),  16'd2);
    idle(2);
    chk("rtype_wb_RegWrite", 16'(bus.wb_RegWrite), 16'd1);
    chk("rtype_wb_MemtoReg", 16'(bus.wb_MemtoReg), 16'd0);
    idle(1);
    chk("rtype_retire_cnt", bus.retire_cnt, 16'd1);

    // load-use: one stall cycle, bubble into EX, then the held instruction issues
    do_reset();
    tick(LW, 1'b1, 5'd0, 5'd5, 1'b0);
    set_in(RTYPE, 1'b1, 5'd5, 5'd0, 1'b0);
    chk("lu_stall_on", 16'(bus.stall_id), 16'd1);
    edge_chk();
    chk("lu_stall_off", 16'(bus.stall_id), 16'd0);
    chk("lu_bubble_ex", 16'(bus.ex_RegDst), 16'd0);
    tick(RTYPE, 1'b1, 5'd5, 5'd0, 1'b0);
    chk("lu_issue_ex", 16'(bus.ex_RegDst), 16'd1);
    idle(3);
    chk("lu_retire_cnt", bus.retire_cnt, 16'd2);

    // load with rt=0 never stalls
    do_reset();
    tick(LW, 1'b1, 5'd0, 5'd0, 1'b0);
    set_in(RTYPE, 1'b1, 5'd0, 5'd0, 1'b0);
    chk("lu_r0_stall", 16'(bus.stall_id), 16'd0);
    edge_chk();
    idle(3);

    // taken branch squashes the two younger instructions
    do_reset();
    tick(BEQ, 1'b1, 5'd0, 5'd0, 1'b0);
    tick(RTYPE, 1'b1, 5'd0, 5'd0, 1'b1);
    set_in(RTYPE, 1'b1, 5'd0, 5'd0, 1'b0);
    chk("br_redirect", 16'(bus.pc_redirect), 16'd1);
    edge_chk();
    chk("br_sq_ex", 16'(bus.ex_RegDst), 16'd0);
    set_in(10'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("br_redirect_once", 16'(bus.pc_redirect), 16'd0);
    edge_chk();
    chk("br_sq_wb1", 16'(bus.wb_RegWrite), 16'd0);
    idle(1);
    chk("br_sq_wb2", 16'(bus.wb_RegWrite), 16'd0);
    idle(1);
    chk("br_retire_cnt", bus.retire_cnt, 16'd1);

    // not-taken branch
    do_reset();
    tick(BEQ, 1'b1, 5'd0, 5'd0, 1'b0);
    tick(10'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    set_in(10'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("br_nt_redirect", 16'(bus.pc_redirect), 16'd0);
    edge_chk();
    idle(3);

    // jump with a coincident load-use hazard: redirect wins
    do_reset();
    tick(JMP, 1'b1, 5'd0, 5'd0, 1'b0);
    tick(LW, 1'b1, 5'd0, 5'd5, 1'b0);
    set_in(RTYPE, 1'b1, 5'd5, 5'd0, 1'b0);
    chk("jmp_redirect", 16'(bus.pc_redirect), 16'd1);
    chk("jmp_no_stall", 16'(bus.stall_id), 16'd0);
    edge_chk();
    idle(3);
    chk("jmp_retire_cnt", bus.retire_cnt, 16'd1);

    // asynchronous reset mid-stream with every stage valid
    do_reset();
    for (int k = 0; k < 4; k++) tick(RTYPE, 1'b1, 5'd0, 5'd0, 1'b0);
    set_in(LW, 1'b1, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_retire_cnt", bus.retire_cnt, 16'd0);
    chk("arst_ex_RegDst",  16'(bus.ex_RegDst), 16'd0);
    chk("arst_wb_RegWrite", 16'(bus.wb_RegWrite), 16'd0);
    chk("arst_ex_ALUop",   16'(bus.ex_ALUop), 16'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic; a stalled instruction is re-presented unchanged
    do_reset();
    held = 1'b0;
    c = 10'd0; v = 1'b0; rs = 5'd0; rt = 5'd0;
    for (int i = 0; i < 1500; i++) begin
      if (!held) begin
        c  = 10'($urandom);
        if ($urandom_range(0, 3) != 0) c[5] = 1'b0;
        v  = ($urandom_range(0, 4) != 0);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
      end
      set_in(c, v, rs, rt, 1'($urandom_range(0, 1)));
      held = m_hazard() && !m_redirect();
      edge_chk();
    end
    idle(4);

    // 65536 back-to-back retirements wrap the counter to zero
    do_reset();
    for (int i = 0; i < 65536; i++) tick(RTYPE, 1'b1, 5'd0, 5'd0, 1'b0);
    idle(3);
    chk("wrap_retire_cnt", bus.retire_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
